pc_unit_ras: RTL and testbench

//  Program-counter generator for the MIPS fetch stage; next generation of the basic PC block.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_ras.sv | 69 ++++++
 rtl/pc_unit_ras.sv | 109 ++++++++++
 tb/tb_pc_unit_ras.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and the next-PC select encoding for the fetch PC unit.
// No ports. This package provides:
//   - field widths for the instruction immediate and the jump index
//   - default reset and exception vectors
//   - pc_sel_e, the select that the top-level priority encoder produces
package pc_pkg;

  localparam int IMM_W   = 16;
  localparam int JIDX_W  = 26;
  localparam int INSTR_W = 32;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_0080;

  // SEL_HOLD covers a stalled fetch. A stall is not a target source, but it
  // still has to steer the PC mux.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_RET,
    SEL_EPC,
    SEL_EXC,
    SEL_HOLD
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   push, pop, push_data  stack operations (push and pop may be asserted together)
//   top                   entry at the stack pointer
//   count                 number of valid entries, 0..DEPTH
// A push onto a full stack overwrites the oldest entry. A pop on an empty
// stack does nothing. Push and pop together replace the top entry, provided
// the stack holds at least one entry.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           top,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, wr_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff, wr_en;

  always_comb begin
    pop_eff = pop && (count_q != '0);
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_ptr  = ptr_q;
    if (push && pop_eff) begin
      wr_en = 1'b1;
    end else if (push) begin
      // DEPTH is a power of two, so the pointer wraps on its own.
      wr_en  = 1'b1;
      wr_ptr = ptr_q + PTR_W'(1);
      ptr_d  = ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
    end else if (pop_eff) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset; count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= push_data;
  end

  assign top   = mem_q[ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with exception entry/return and a return-address stack.
// Ports:
//   clk, reset (async, active low)
//   instr                  current instruction; imm16 and jidx are taken from it
//   stall, jump, link, branch, jr, ret, exc, eret   request flags from control/decode
//   jr_target              register operand used by jr, and by ret when the stack is empty
//   pc_out, pc_plus4, epc  fetch address, fetch address + 4, saved exception PC
//   ras_count              number of valid return-stack entries
// Next-PC priority: exc > eret > stall > ret > jr > jump > branch > sequential.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEFAULT_EXC_VEC),
  parameter int                RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INSTR_W-1:0]         instr,
  input  logic                       stall,
  input  logic                       jump,
  input  logic                       link,
  input  logic                       branch,
  input  logic                       jr,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          jr_target,
  input  logic                       exc,
  input  logic                       eret,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [ADDR_W-1:0]          pc_plus4,
  output logic [ADDR_W-1:0]          epc,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [ADDR_W-1:0] br_off, br_target, j_target, ras_top;
  logic              active, ras_push, ras_pop, unused_instr;
  pc_sel_e           sel;

  assign unused_instr = ^instr[INSTR_W-1:JIDX_W];

  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign br_off    = {{(ADDR_W-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  assign br_target = pc_plus4 + br_off;
  assign j_target  = {pc_plus4[ADDR_W-1:28], instr[JIDX_W-1:0], 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (exc)                            sel = SEL_EXC;
    else if (eret)                      sel = SEL_EPC;
    else if (stall)                     sel = SEL_HOLD;
    else if (ret && (ras_count != '0))  sel = SEL_RET;
    else if (ret || jr)                 sel = SEL_JR;   // ret with an empty stack falls back to jr_target
    else if (jump)                      sel = SEL_J;
    else if (branch)                    sel = SEL_BR;
  end

  always_comb begin
    pc_d  = pc_plus4;
    epc_d = epc_q;
    case (sel)
      SEL_EXC: begin
        pc_d  = EXC_VEC;
        epc_d = pc_q;
      end
      SEL_EPC:  pc_d = epc_q;
      SEL_HOLD: pc_d = pc_q;
      SEL_RET:  pc_d = ras_top;
      SEL_JR:   pc_d = jr_target;
      SEL_J:    pc_d = j_target;
      SEL_BR:   pc_d = br_target;
      default:  pc_d = pc_plus4;
    endcase
  end

  // A jal still pushes when a ret wins the target in the same cycle; the
  // stack then performs a combined pop+push.
  assign active   = !(exc || eret || stall);
  assign ras_push = active && jump && link;
  assign ras_pop  = active && ret;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign pc_out = pc_q;
  assign epc    = epc_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, jr_target;
  logic        stall, jump, link, branch, jr, ret, exc, eret;
  logic [31:0] pc_out, pc_plus4, epc;
  logic [2:0]  ras_count;

  pc_unit_ras dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .stall     (stall),
    .jump      (jump),
    .link      (link),
    .branch    (branch),
    .jr        (jr),
    .ret       (ret),
    .jr_target (jr_target),
    .exc       (exc),
    .eret      (eret),
    .pc_out    (pc_out),
    .pc_plus4  (pc_plus4),
    .epc       (epc),
    .ras_count (ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    int          cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc, m_epc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic clr();
    instr = '0; jr_target = '0;
    stall = 0; jump = 0; link = 0; branch = 0; jr = 0; ret = 0; exc = 0; eret = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_ras.delete();
    sb.delete();
  endtask

  // Predict the state after the next edge from the current inputs, queue it,
  // clock the DUT, then compare against the queued prediction.
  task automatic cyc();
    exp_t        e;
    logic [31:0] pp4, tgt;
    bit          pop_eff;
    pp4 = m_pc + 32'd4;
    check("pc_plus4", {32'h0, pc_plus4}, {32'h0, pp4});
    pop_eff = 0;
    if (exc) begin
      m_epc = m_pc;
      m_pc  = 32'h80;
    end else if (eret) begin
      m_pc = m_epc;
    end else if (!stall) begin
      if (ret && m_ras.size() > 0) begin
        tgt = m_ras[$];
        pop_eff = 1;
      end else if (ret || jr) tgt = jr_target;
      else if (jump)          tgt = {pp4[31:28], instr[25:0], 2'b00};
      else if (branch)        tgt = pp4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      else                    tgt = pp4;
      if (pop_eff && jump && link) begin
        m_ras[m_ras.size()-1] = pp4;
      end else begin
        if (pop_eff) void'(m_ras.pop_back());
        if (jump && link) begin
          m_ras.push_back(pp4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end
      m_pc = tgt;
    end
    e.pc = m_pc; e.epc = m_epc; e.cnt = m_ras.size();
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underrun", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("pc_out", {32'h0, pc_out}, {32'h0, e.pc});
      check("epc", {32'h0, epc}, {32'h0, e.epc});
      check("ras_count", 64'(ras_count), 64'(e.cnt));
    end
    clr();
  endtask

  task automatic set_pc(input logic [31:0] a);
    jr = 1; jr_target = a; cyc();
  endtask

  task automatic jal(input logic [25:0] idx);
    jump = 1; link = 1; instr = {6'd3, idx}; cyc();
  endtask

  task automatic do_ret(input logic [31:0] fallback);
    ret = 1; jr_target = fallback; cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", {32'h0, pc_out}, 64'h0);
    check("rst_epc", {32'h0, epc}, 64'h0);
    check("rst_cnt", 64'(ras_count), 64'h0);
    reset = 1;

    // Sequential fetch after reset release
    repeat (3) cyc();
    check("seq_12", {32'h0, pc_out}, 64'hC);

    // Backward branch and region-preserving jump
    set_pc(32'h10);
    branch = 1; instr = 32'h0000_FFFC; cyc();
    check("branch_back", {32'h0, pc_out}, 64'h4);
    set_pc(32'hF000_0000);
    jump = 1; instr = 32'h0000_0040; cyc();
    check("jump_region", {32'h0, pc_out}, 64'hF000_0100);
    branch = 1; instr = 32'h0000_0003; cyc();

    // jal and a matching return
    set_pc(32'h20);
    jal(26'h100);
    check("jal_pc", {32'h0, pc_out}, 64'h400);
    check("jal_cnt", 64'(ras_count), 64'd1);
    do_ret(32'hDEAD_0000);
    check("ret_pc", {32'h0, pc_out}, 64'h24);
    check("ret_cnt", 64'(ras_count), 64'd0);

    // Overflow: five pushes into four entries, then drain past empty
    for (int i = 0; i < 5; i++) begin
      set_pc(32'h1000 + 32'(i) * 32'h100);
      jal(26'h200);
    end
    check("ovf_cnt", 64'(ras_count), 64'd4);
    for (int i = 4; i >= 1; i--) begin
      do_ret(32'h0);
      check("pop_order", {32'h0, pc_out}, {32'h0, 32'h1004 + 32'(i) * 32'h100});
    end
    do_ret(32'h500);
    check("empty_ret", {32'h0, pc_out}, 64'h500);
    check("empty_cnt", 64'(ras_count), 64'd0);

    // ret combined with jal: top entry is replaced, count unchanged
    set_pc(32'h2000);
    jal(26'h10);
    ret = 1; jump = 1; link = 1; instr = 32'h0000_0020; cyc();
    check("retjal_pc", {32'h0, pc_out}, 64'h2004);
    ret = 1; cyc();

    // Stall holds the PC, exc overrides the stall, eret returns
    set_pc(32'h30);
    jal(26'hC);
    for (int i = 0; i < 3; i++) begin
      stall = 1; jump = 1; link = 1; instr = 32'h0000_0100; cyc();
    end
    check("stall_pc", {32'h0, pc_out}, 64'h30);
    stall = 1; exc = 1; jump = 1; link = 1; cyc();
    check("exc_pc", {32'h0, pc_out}, 64'h80);
    check("exc_epc", {32'h0, epc}, 64'h30);
    eret = 1; ret = 1; cyc();
    check("eret_pc", {32'h0, pc_out}, 64'h30);
    check("eret_cnt", 64'(ras_count), 64'd1);

    // Async reset pulse between edges
    #2 reset = 0;
    #1;
    check("async_pc", {32'h0, pc_out}, 64'h0);
    check("async_epc", {32'h0, epc}, 64'h0);
    check("async_cnt", 64'(ras_count), 64'h0);
    #1 reset = 1;
    model_reset();
    cyc();
    check("post_rst", {32'h0, pc_out}, 64'h4);

    // Sequential wrap at the top of the address space
    set_pc(32'hFFFF_FFFC);
    cyc();
    check("wrap", {32'h0, pc_out}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
